// File: rtl/led_pwm_driver_if.sv
// Bus between the processor core and the LED PWM driver: per-LED commands in,
// LED pin drive and frame marker out.
interface led_pwm_driver_if #(
  parameter int NUM_LEDS = 18
);
  logic [8*NUM_LEDS-1:0] led_commands;
  logic [NUM_LEDS-1:0]   led_pins;
  logic                  frame_start;

  modport master (
    output led_commands,
    input  led_pins,
    input  frame_start
  );

  modport slave (
    input  led_commands,
    output led_pins,
    output frame_start
  );
endinterface

// File: rtl/led_pwm_driver.sv
// Frame-based PWM driver for the board LEDs: per-LED mode and duty commands are
// snapshotted once per 64-step frame and rendered as registered pin levels.
module led_pwm_driver #(
  parameter int NUM_LEDS     = 18,
  parameter int PWM_PRESCALE = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clock,
  input  logic             reset,
  led_pwm_driver_if.slave  bus
);

  localparam int PRESC_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PWM_PRESCALE - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [5:0]         PWM_MAX   = 6'd63;

  typedef enum logic [1:0] {
    ModeOff      = 2'b00,
    ModeSolid    = 2'b01,
    ModeBlink    = 2'b10,
    ModeAltBlink = 2'b11
  } ledMode_e;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [5:0]            pwm_q, pwm_d;
  logic [BLINK_W-1:0]    blink_q, blink_d;
  logic                  phase_q, phase_d;
  logic [8*NUM_LEDS-1:0] shadow_q, shadow_d;
  logic [NUM_LEDS-1:0]   pins_q, pins_d;
  logic                  frameStart_q, frameStart_d;

  logic tick;
  logic boundary;

  // Level of one LED for the current PWM step; duty 63 is full-on with no dark step.
  function automatic logic ledLevel(input logic [7:0] cmd, input logic [5:0] cnt,
                                    input logic phase);
    logic pwmOn;
    pwmOn = (cmd[5:0] == PWM_MAX) || (cnt < cmd[5:0]);
    case (ledMode_e'(cmd[7:6]))
      ModeSolid:    ledLevel = pwmOn;
      ModeBlink:    ledLevel = pwmOn && phase;
      ModeAltBlink: ledLevel = pwmOn && !phase;
      default:      ledLevel = 1'b0;
    endcase
  endfunction

  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (pwm_q == PWM_MAX);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    pwm_d   = tick ? pwm_q + 6'd1 : pwm_q;
  end

  // Commands, frame marker and blink timebase only move on the frame boundary.
  always_comb begin
    shadow_d     = shadow_q;
    blink_d      = blink_q;
    phase_d      = phase_q;
    frameStart_d = boundary;
    if (boundary) begin
      shadow_d = bus.led_commands;
      if (blink_q == BLINK_MAX) begin
        blink_d = '0;
        phase_d = !phase_q;
      end else begin
        blink_d = blink_q + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    pins_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pins_d[i] = ledLevel(shadow_q[8*i +: 8], pwm_q, phase_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q      <= '0;
      pwm_q        <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      shadow_q     <= '0;
      pins_q       <= '0;
      frameStart_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pwm_q        <= pwm_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      shadow_q     <= shadow_d;
      pins_q       <= pins_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign bus.led_pins    = pins_q;
  assign bus.frame_start = frameStart_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench for led_pwm_driver with a 64-cycle frame (prescale 1) and
// two-frame blink half-phase.
module tb_led_pwm_driver;

  localparam int NUM_LEDS = 18;
  localparam int PRESC    = 1;
  localparam int BF       = 2;
  localparam int CW       = 8 * NUM_LEDS;

  typedef struct packed {
    logic [NUM_LEDS-1:0] pins;
    logic                fs;
  } expT;

  logic clock = 1'b0;
  logic reset = 1'b1;

  led_pwm_driver_if #(.NUM_LEDS(NUM_LEDS)) bus ();

  led_pwm_driver #(
    .NUM_LEDS    (NUM_LEDS),
    .PWM_PRESCALE(PRESC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  expT                 sbQ[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  mPos = 0;
  logic [CW-1:0]       mShadow = '0;
  logic [NUM_LEDS-1:0] obsPins;
  logic                obsFs;
  logic [CW-1:0]       curCmd;
  int                  frameHighs[NUM_LEDS];
  int                  frameFirstOn[NUM_LEDS];
  int                  frameLen;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference pin pattern given the PWM step within the frame, the captured
  // commands and the blink phase.
  function automatic logic [NUM_LEDS-1:0] modelPins(input int pos, input logic [CW-1:0] sh,
                                                    input logic ph);
    logic [NUM_LEDS-1:0] r;
    logic [7:0]          c;
    int                  duty;
    logic                lit;
    r = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      c    = sh[8*i +: 8];
      duty = int'(c[5:0]);
      lit  = (duty == 63) || (pos < duty);
      case (c[7:6])
        2'b01:   r[i] = lit;
        2'b10:   r[i] = lit && ph;
        2'b11:   r[i] = lit && !ph;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // One clock: drive at the falling edge, predict what the next rising edge
  // registers, then compare shortly after that edge.
  task automatic applyStimulus(input logic rst, input logic [CW-1:0] cmd);
    expT e;
    @(negedge clock);
    reset            = rst;
    bus.led_commands = cmd;
    if (rst) begin
      e.pins  = '0;
      e.fs    = 1'b0;
      mPos    = 0;
      mShadow = '0;
    end else begin
      e.pins = modelPins(mPos % 64, mShadow, (((mPos / 64) / BF) % 2) == 1);
      e.fs   = ((mPos % 64) == 63);
      if (e.fs) mShadow = cmd;
      mPos++;
    end
    sbQ.push_back(e);
    @(posedge clock);
    #1;
    obsPins = bus.led_pins;
    obsFs   = bus.frame_start;
    e = sbQ.pop_front();
    checkOutput("pins", 32'(obsPins), 32'(e.pins));
    checkOutput("frame_start", 32'(obsFs), 32'(e.fs));
  endtask

  task automatic waitFrameStart(output int waited);
    waited = 0;
    do begin
      applyStimulus(1'b0, curCmd);
      waited++;
    end while (!obsFs && waited < 200);
    if (!obsFs) checkOutput("frame_start_timeout", 32'd0, 32'd1);
  endtask

  // Runs from one frame_start to the next, counting lit cycles per LED; the
  // command switches to switchCmd once the driven step reaches switchAt.
  task automatic measureFrame(input int switchAt, input logic [CW-1:0] switchCmd);
    int k;
    for (int i = 0; i < NUM_LEDS; i++) begin
      frameHighs[i]   = 0;
      frameFirstOn[i] = -1;
    end
    k = 0;
    do begin
      if (k >= switchAt) curCmd = switchCmd;
      applyStimulus(1'b0, curCmd);
      k++;
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (obsPins[i]) begin
          frameHighs[i]++;
          if (frameFirstOn[i] < 0) frameFirstOn[i] = k;
        end
      end
    end while (!obsFs && k < 200);
    frameLen = k;
    if (!obsFs) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int                  w;
    int                  fsCount;
    int                  others;
    logic [NUM_LEDS-1:0] pinsOr;
    logic [CW-1:0]       newCmd;
    int                  blinkExp[4];

    bus.led_commands = '0;

    $display("[TB] reset hold");
    curCmd = {NUM_LEDS{8'h7F}};
    repeat (3) applyStimulus(1'b1, curCmd);
    fsCount = 0;
    pinsOr  = '0;
    repeat (64) begin
      applyStimulus(1'b0, curCmd);
      if (obsFs) fsCount++;
      pinsOr |= obsPins;
    end
    checkOutput("s1_fs_count", 32'(fsCount), 32'd1);
    checkOutput("s1_fs_on_edge64", 32'(obsFs), 32'd1);
    checkOutput("s1_pins_dark", 32'(pinsOr), 32'd0);
    applyStimulus(1'b0, curCmd);
    checkOutput("s1_pins_lit", 32'(obsPins), 32'({NUM_LEDS{1'b1}}));

    $display("[TB] duty 16 on LED0");
    curCmd = '0;
    curCmd[7:0] = 8'h50;
    waitFrameStart(w);
    repeat (2) begin
      measureFrame(999, curCmd);
      others = 0;
      for (int i = 1; i < NUM_LEDS; i++) others += frameHighs[i];
      checkOutput("s2_highs0", 32'(frameHighs[0]), 32'd16);
      checkOutput("s2_first0", 32'(frameFirstOn[0]), 32'd1);
      checkOutput("s2_others", 32'(others), 32'd0);
      checkOutput("s2_len", 32'(frameLen), 32'd64);
    end

    $display("[TB] duty extremes");
    curCmd = '0;
    curCmd[8*1 +: 8] = 8'h7F;
    curCmd[8*2 +: 8] = 8'h40;
    curCmd[8*5 +: 8] = 8'h3F;
    waitFrameStart(w);
    repeat (2) begin
      measureFrame(999, curCmd);
      checkOutput("s3_highs1", 32'(frameHighs[1]), 32'd64);
      checkOutput("s3_highs2", 32'(frameHighs[2]), 32'd0);
      checkOutput("s3_highs5", 32'(frameHighs[5]), 32'd0);
    end

    $display("[TB] mid-frame write");
    curCmd = '0;
    curCmd[7:0] = 8'h50;
    waitFrameStart(w);
    newCmd = curCmd;
    newCmd[7:0] = 8'h60;
    measureFrame(10, newCmd);
    checkOutput("s5_old_frame", 32'(frameHighs[0]), 32'd16);
    measureFrame(999, curCmd);
    checkOutput("s5_new_frame", 32'(frameHighs[0]), 32'd32);

    $display("[TB] blink after reset");
    curCmd = '0;
    curCmd[8*3 +: 8] = 8'hBF;
    curCmd[8*4 +: 8] = 8'hFF;
    applyStimulus(1'b1, curCmd);
    waitFrameStart(w);
    checkOutput("s4_first_fs", 32'(w), 32'd64);
    blinkExp[0] = 0;
    blinkExp[1] = 64;
    blinkExp[2] = 64;
    blinkExp[3] = 0;
    for (int f = 0; f < 4; f++) begin
      measureFrame(999, curCmd);
      checkOutput("s4_blink", 32'(frameHighs[3]), 32'(blinkExp[f]));
      checkOutput("s4_altblink", 32'(frameHighs[4]), 32'(64 - blinkExp[f]));
      checkOutput("s4_spacing", 32'(frameLen), 32'd64);
    end

    $display("[TB] mid-frame reset");
    curCmd = '0;
    curCmd[7:0] = 8'h7F;
    waitFrameStart(w);
    repeat (30) applyStimulus(1'b0, curCmd);
    checkOutput("s6_lit_before", 32'(obsPins[0]), 32'd1);
    applyStimulus(1'b1, curCmd);
    checkOutput("s6_pins_cleared", 32'(obsPins), 32'd0);
    waitFrameStart(w);
    checkOutput("s6_fs_after_release", 32'(w), 32'd64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
